sync_to_wchb_bridge: RTL

// - Clocked-to-asynchronous entry stage. Accepts a valid/ready stream in the clk domain.
// - Drives the 4-phase bundled-data req/data pair into the first wchb_cell of the async pipeline.
// - Samples that cell's ack back through a synchronizer.
// - Buffers up to BUF_DEPTH words so that upstream is not stalled for a whole handshake.

---
 rtl/async_pkg.sv | 4 +
 rtl/sync_ff.sv | 16 +
 rtl/sync_to_wchb_bridge.sv | 71 +++++++
 3 files changed

// File: rtl/async_pkg.sv
// async_pkg: shared handshake state type for the clocked-to-async bridge
package async_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, REQ_HI, RTZ} bridge_state_t;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: flop-chain synchronizer for an asynchronous level input
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;
  // shift the async level through the flop chain
  always_ff @(posedge clk or posedge rst)
    if (rst) chain <= '0;
    else chain <= {chain[STAGES-2:0], d};
  assign q = chain[STAGES-1];
endmodule

// File: rtl/sync_to_wchb_bridge.sv
// sync_to_wchb_bridge: buffers a valid/ready stream and drives a 4-phase bundled-data handshake
module sync_to_wchb_bridge
  import async_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int BUF_DEPTH   = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TMO_W       = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              o_req,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ack,
  output logic              o_busy,
  output logic              o_timeout
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST = ~TMO_W'(1);
  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [TMO_W-1:0] tmo_cnt;
  logic full, empty, push, pop, ack_s, step;
  bridge_state_t state, state_nx;
  assign empty   = wr_ptr == rd_ptr;
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign s_ready = !full;
  assign push    = s_valid && !full;
  assign pop     = state == IDLE && !empty;
  assign o_busy  = state != IDLE || !empty;
  assign step    = state_nx != state;
  sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (.clk(clk), .rst(rst), .d(i_ack), .q(ack_s));
  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= s_data;
  // FIFO pointers with natural wrap
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(push);
      rd_ptr <= rd_ptr + (AW+1)'(pop);
    end
  // handshake sequencing; SETUP also holds off while a stale ack is still high
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE   ? (empty ? IDLE : SETUP) :
               state == SETUP  ? (ack_s ? SETUP : REQ_HI) :
               state == REQ_HI ? (ack_s ? RTZ : REQ_HI) :
                                 (ack_s ? RTZ : IDLE);
  end
  // state, glitch-free registered req, data latch and sticky phase timeout
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      o_req     <= 1'b0;
      o_data    <= '0;
      tmo_cnt   <= '0;
      o_timeout <= 1'b0;
    end else begin
      state   <= state_nx;
      o_req   <= state_nx == REQ_HI;
      tmo_cnt <= (step || state == IDLE) ? '0 : tmo_cnt + TMO_W'(tmo_cnt != '1);
      if (pop) o_data <= mem[rd_ptr[AW-1:0]];
      if (!step && state != IDLE && tmo_cnt == TMO_LAST) o_timeout <= 1'b1;
    end
endmodule
